// File: rtl/half_adder_behav_pkg.sv
// Shared constants for the half-adder slice: default lane/counter widths and
// the single-lane truth table that benches can iterate over.
package half_adder_behav_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned DEFAULT_CNT_W = 16;
  localparam int unsigned LANE_TT_ROWS  = 4;

  // One row of the per-lane truth table: inputs followed by expected outputs.
  typedef struct packed {
    logic a;
    logic b;
    logic sum;
    logic cout;
  } lane_tt_t;

  localparam lane_tt_t LANE_TT [LANE_TT_ROWS] = '{
    '{a: 1'b0, b: 1'b0, sum: 1'b0, cout: 1'b0},
    '{a: 1'b0, b: 1'b1, sum: 1'b1, cout: 1'b0},
    '{a: 1'b1, b: 1'b0, sum: 1'b1, cout: 1'b0},
    '{a: 1'b1, b: 1'b1, sum: 1'b0, cout: 1'b1}
  };

endpackage : half_adder_behav_pkg

// File: rtl/half_adder_cell.sv
// Single-lane combinational half adder.
// Ports:
//   a, b  : 1-bit addends
//   sum   : a XOR b
//   cout  : a AND b
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule : half_adder_cell

// File: rtl/half_adder_behav.sv
// WIDTH independent half-adder lanes with combinational outputs, a registered
// copy of those outputs, and a saturating count of cycles that saw any carry.
// Ports:
//   clk        : rising-edge clock for registered outputs and counter
//   rst        : asynchronous active-high reset (clears registers only)
//   a, b       : WIDTH-bit addends, one bit per lane
//   sum, cout  : combinational per-lane sum/carry (independent of clk/rst)
//   sum_q      : sum registered on clk
//   cout_q     : cout registered on clk
//   carry_cnt  : number of edges on which any cout lane was 1, saturating
module half_adder_behav
  import half_adder_behav_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] cout_q,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] cout_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             any_carry;

  // One independent cell per lane; no carry chaining between lanes.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
    half_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .sum  (sum[i]),
      .cout (cout[i])
    );
  end

  // Next-state: capture lane outputs, bump counter unless already saturated.
  always_comb begin
    sum_d     = sum;
    cout_d    = cout;
    cnt_d     = cnt_q;
    any_carry = |cout;
    if (any_carry && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output registers and carry counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= '0;
      cnt_q  <= '0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;

endmodule : half_adder_behav

// File: tb/tb_half_adder_behav.sv
module tb_half_adder_behav;
  import half_adder_behav_pkg::*;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Free-running clock shared by the 4-lane and saturation instances.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Manually pulsed clock for the 1-lane instance (idle at start).
  logic clk1 = 1'b0;

  // ---------------- 1-lane, default counter ----------------
  logic       rst1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [0:0] s1, c1, sq1, cq1;
  logic [15:0] cnt1;

  half_adder_behav #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk1), .rst(rst1), .a(a1), .b(b1),
    .sum(s1), .cout(c1), .sum_q(sq1), .cout_q(cq1), .carry_cnt(cnt1)
  );

  // ---------------- 4-lane, random scoreboard ----------------
  logic        rst4 = 1'b1;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [3:0]  s4, c4, sq4, cq4;
  logic [15:0] cnt4;

  half_adder_behav #(.WIDTH(4), .CNT_W(16)) u_w4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4),
    .sum(s4), .cout(c4), .sum_q(sq4), .cout_q(cq4), .carry_cnt(cnt4)
  );

  // ---------------- 1-lane, 3-bit counter (saturation) ----------------
  logic       rst_s = 1'b1;
  logic [0:0] as_ = '0, bs_ = '0;
  logic [0:0] ss, cs, sqs, cqs;
  logic [2:0] cnts;

  half_adder_behav #(.WIDTH(1), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst_s), .a(as_), .b(bs_),
    .sum(ss), .cout(cs), .sum_q(sqs), .cout_q(cqs), .carry_cnt(cnts)
  );

  typedef struct {
    logic [3:0]  s;
    logic [3:0]  c;
    int unsigned cnt;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse1();
    clk1 = 1'b1;
    #5;
    clk1 = 1'b0;
    #5;
  endtask

  // Reference model: each lane is plain 1-bit addition; sum is the low bit,
  // carry the high bit of the 2-bit total.
  function automatic void lane_add(input logic [3:0] a, input logic [3:0] b,
                                   output logic [3:0] s, output logic [3:0] c);
    for (int i = 0; i < 4; i++) begin
      int unsigned tot;
      tot  = int'(a[i]) + int'(b[i]);
      s[i] = (tot % 2) == 1;
      c[i] = (tot / 2) == 1;
    end
  endfunction

  // Monitor: registered outputs appear one edge after the stimulus.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("w4 sum_q",     32'(sq4),  32'(e.s));
      chk("w4 cout_q",    32'(cq4),  32'(e.c));
      chk("w4 carry_cnt", 32'(cnt4), e.cnt);
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned cnt_m;
    int unsigned guard;
    logic [3:0]  es, ec;
    logic        ea, eb;

    // ---- 1-lane combinational with clock idle ----
    a1 = 1'b0; b1 = 1'b0; #1;
    chk("w1 idle 00 sum", 32'(s1), 0);
    chk("w1 idle 00 cout", 32'(c1), 0);
    #20; a1 = 1'b1; b1 = 1'b0; #1;
    chk("w1 idle 10 sum", 32'(s1), 1);
    chk("w1 idle 10 cout", 32'(c1), 0);
    #20; a1 = 1'b1; b1 = 1'b1; #1;
    chk("w1 idle 11 sum", 32'(s1), 0);
    chk("w1 idle 11 cout", 32'(c1), 1);

    // ---- 1-lane exhaustive, combinational and registered ----
    rst1 = 1'b1; #1;
    chk("w1 reset sum_q", 32'(sq1), 0);
    chk("w1 reset cnt", 32'(cnt1), 0);
    rst1 = 1'b0; #1;
    for (int k = 0; k < int'(LANE_TT_ROWS); k++) begin
      ea = LANE_TT[k].a;
      eb = LANE_TT[k].b;
      a1 = ea; b1 = eb; #1;
      chk("w1 tt sum", 32'(s1), 32'((int'(ea) + int'(eb)) % 2));
      chk("w1 tt cout", 32'(c1), 32'((int'(ea) + int'(eb)) / 2));
      pulse1();
      chk("w1 tt sum_q", 32'(sq1), 32'((int'(ea) + int'(eb)) % 2));
      chk("w1 tt cout_q", 32'(cq1), 32'((int'(ea) + int'(eb)) / 2));
    end
    chk("w1 tt cnt", 32'(cnt1), 1);

    // ---- carry hold / no-carry hold ----
    rst1 = 1'b1; #1; rst1 = 1'b0; #1;
    a1 = 1'b1; b1 = 1'b1;
    repeat (5) pulse1();
    chk("w1 hold11 cnt", 32'(cnt1), 5);
    a1 = 1'b1; b1 = 1'b0;
    repeat (5) pulse1();
    chk("w1 hold10 cnt", 32'(cnt1), 5);
    chk("w1 hold10 sum_q", 32'(sq1), 1);

    // ---- asynchronous reset between edges ----
    rst1 = 1'b1; #1;
    chk("w1 async rst cnt", 32'(cnt1), 0);
    chk("w1 async rst sum_q", 32'(sq1), 0);
    chk("w1 async rst cout_q", 32'(cq1), 0);
    chk("w1 async rst sum", 32'(s1), 1);
    chk("w1 async rst cout", 32'(c1), 0);
    a1 = 1'b1; b1 = 1'b1; #1;
    chk("w1 in-rst sum", 32'(s1), 0);
    chk("w1 in-rst cout", 32'(c1), 1);

    // ---- 4-lane: reset state while inputs toggle ----
    @(negedge clk);
    a4 = 4'b1010; b4 = 4'b0110; #1;
    chk("w4 rst sum_q", 32'(sq4), 0);
    chk("w4 rst cout_q", 32'(cq4), 0);
    chk("w4 rst cnt", 32'(cnt4), 0);
    chk("w4 rst sum", 32'(s4), 32'(4'b1100));
    chk("w4 rst cout", 32'(c4), 32'(4'b0010));

    // ---- 4-lane random traffic through the scoreboard ----
    rst4  = 1'b0;
    cnt_m = 0;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) begin
        a4 = 4'b1111; b4 = 4'b0101;
      end else begin
        a4 = 4'($urandom_range(15, 0));
        b4 = 4'($urandom_range(15, 0));
      end
      #1;
      lane_add(a4, b4, es, ec);
      chk("w4 sum", 32'(s4), 32'(es));
      chk("w4 cout", 32'(c4), 32'(ec));
      if (ec != 4'd0 && cnt_m < 65535) cnt_m++;
      exp_q.push_back('{s: es, c: ec, cnt: cnt_m});
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    chk("w4 scoreboard drained", 32'(exp_q.size()), 0);

    // ---- 4-lane mid-cycle reset ----
    @(negedge clk);
    a4 = 4'b0011; b4 = 4'b0001;
    rst4 = 1'b1; #1;
    chk("w4 mid rst sum_q", 32'(sq4), 0);
    chk("w4 mid rst cout_q", 32'(cq4), 0);
    chk("w4 mid rst cnt", 32'(cnt4), 0);
    chk("w4 mid rst sum", 32'(s4), 32'(4'b0010));
    chk("w4 mid rst cout", 32'(c4), 32'(4'b0001));
    @(posedge clk); #1;
    chk("w4 held rst cnt", 32'(cnt4), 0);
    chk("w4 held rst sum_q", 32'(sq4), 0);

    // ---- saturation with a 3-bit counter ----
    @(negedge clk);
    as_ = 1'b1; bs_ = 1'b1;
    rst_s = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("sat cnt at 7 edges", 32'(cnts), 7);
    repeat (3) @(posedge clk);
    #1;
    chk("sat cnt at 10 edges", 32'(cnts), 7);
    chk("sat cout_q", 32'(cqs), 1);
    @(negedge clk);
    rst_s = 1'b1; #1;
    chk("sat rst cnt", 32'(cnts), 0);
    chk("sat rst cout_q", 32'(cqs), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_half_adder_behav

// File: doc/half_adder_behav.md
HALF_ADDER_BEHAV -- requirements
Module: half_adder_behav

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of each addend lane (number of independent half-adder lanes).
REQ-002 Parameter: CNT_W, default 16, width of the carry-event counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock for the registered outputs and the counter.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: a  input  WIDTH  addend A.
REQ-007 Port: b  input  WIDTH  addend B.
REQ-008 Port: sum  output  WIDTH  combinational sum, per lane.
REQ-009 Port: cout  output  WIDTH  combinational carry, per lane.
REQ-010 Port: sum_q  output  WIDTH  sum registered on clk.
REQ-011 Port: cout_q  output  WIDTH  cout registered on clk.
REQ-012 Port: carry_cnt  output  CNT_W  count of clock edges on which any cout lane was 1.

Function
REQ-013 sum SHALL equal a XOR b bitwise, purely combinational, zero latency.
REQ-014 cout SHALL equal a AND b bitwise, purely combinational, zero latency.
REQ-015 sum and cout SHALL be valid even when clk is idle and rst is undriven or low; they SHALL NOT depend on clk or rst.
REQ-016 Truth table per lane: 00->sum0,cout0; 01->1,0; 10->1,0; 11->0,1.
REQ-017 sum_q/cout_q SHALL capture sum/cout on each rising clk edge, giving 1-cycle latency.
REQ-018 carry_cnt SHALL increment by 1 on each rising clk edge where the reduction OR of cout is 1.
REQ-019 carry_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-020 Lanes SHALL be independent; no carry SHALL propagate between lanes.
REQ-021 Input changes between edges SHALL affect only sum/cout, not registered outputs, until the next edge.

Reset
REQ-022 Asserting rst SHALL immediately, without a clock edge, force sum_q=0, cout_q=0, carry_cnt=0.
REQ-023 While rst is high, registered outputs SHALL hold 0; sum/cout SHALL continue to follow a/b.
REQ-024 After rst deasserts, the first rising edge SHALL load sum_q/cout_q and may increment carry_cnt normally.
REQ-025 rst asserted mid-count SHALL clear carry_cnt, including from saturation.

Structure
REQ-026 A shared package SHALL hold the default WIDTH and CNT_W constants and a lane truth-table constant used by benches.
REQ-027 One sub-module, half_adder_cell (1-bit a,b -> sum,cout, combinational), SHALL be instantiated WIDTH times via generate.
REQ-028 Registers and counter SHALL reside in the top module in one always block sensitive to posedge clk and posedge rst.

Verification
REQ-029 WIDTH=1, clk idle: a=0,b=0 -> sum=0,cout=0; after 20 ns a=1,b=0 -> sum=1,cout=0; after 20 ns a=1,b=1 -> sum=0,cout=1.
REQ-030 Exhaustive a/b (WIDTH=1, all 4 combos) -> sum/cout match REQ-016; sum_q/cout_q match one clock later.
REQ-031 WIDTH=4: a=4'b1111, b=4'b0101 -> sum=4'b1010, cout=4'b0101; next edge carry_cnt increments by 1.
REQ-032 Hold a=1,b=1 for 5 edges from reset -> carry_cnt=5; hold a=1,b=0 for 5 further edges -> carry_cnt remains 5.
REQ-033 CNT_W=3, a=b=1 for 10 edges -> carry_cnt saturates at 7.
REQ-034 Assert rst between edges with carry_cnt=5, sum_q=1 -> carry_cnt, sum_q, cout_q go 0 immediately; sum/cout unaffected.
